// File: rtl/acc_sched_pkg.sv
// Shared types and default dimensions for the round-robin accumulator scheduler.
package acc_sched_pkg;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_DW      = 8;
    localparam int unsigned DEF_SW      = 16;
    localparam int unsigned DEF_LENW    = 8;
    localparam int unsigned DEF_ACC_LAT = 1;
    localparam int unsigned IDW         = $clog2(DEF_NREQ);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_e;

endpackage

// File: rtl/acc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import acc_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!any_c && req[cand]) begin
                any_c         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/acc_sched.sv
// Round-robin scheduler sharing one external accumulator between NREQ sample streams.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned SW      = DEF_SW,
    parameter int unsigned LENW    = DEF_LENW,
    parameter int unsigned ACC_LAT = DEF_ACC_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*LENW-1:0]     req_len,
    input  logic [NREQ*DW-1:0]       smp_data,
    input  logic [NREQ-1:0]          smp_valid,
    output logic [NREQ-1:0]          smp_ready,
    output logic                     acc_rst,
    output logic [DW-1:0]            acc_in,
    input  logic [SW-1:0]            acc_sum,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [SW-1:0]            res_sum,
    input  logic                     res_ready,
    output logic                     busy
);

    localparam int unsigned IW  = $clog2(NREQ);
    localparam int unsigned DCW = $clog2(ACC_LAT + 1) + 1;

    state_e          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   g, g_nxt;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic            arb_any;
    logic [LENW-1:0] len, len_nxt;
    logic [LENW-1:0] cnt, cnt_nxt;
    logic [LENW-1:0] sel_len;
    logic [DW-1:0]   sel_data;
    logic [DCW-1:0]  dcnt, dcnt_nxt;
    logic            acc_rst_nxt;
    logic [DW-1:0]   acc_in_nxt;
    logic            res_valid_nxt;
    logic [IW-1:0]   res_id_nxt;
    logic [SW-1:0]   res_sum_nxt;
    logic            hs;
    logic            last_smp;
    logic            drain_last;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .any_c   (arb_any)
    );

    // Length of the candidate winner and sample of the current owner.
    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) sel_len = req_len[i*LENW +: LENW];
            if (g == IW'(i))  sel_data = smp_data[i*DW +: DW];
        end
    end

    assign smp_ready  = (state == STREAM) ? (NREQ'(1) << g) : '0;
    assign hs         = smp_valid[g] && smp_ready[g];
    assign last_smp   = (cnt == len - LENW'(1));
    assign drain_last = (dcnt == DCW'(ACC_LAT));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = CLEAR;
            CLEAR:   state_nxt = (len == '0) ? DRAIN : STREAM;
            STREAM:  if (hs && last_smp) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the datapath and registered outputs.
    always_comb begin
        ptr_nxt       = ptr;
        g_nxt         = g;
        len_nxt       = len;
        cnt_nxt       = cnt;
        dcnt_nxt      = dcnt;
        acc_rst_nxt   = 1'b0;
        acc_in_nxt    = '0;
        res_valid_nxt = res_valid;
        res_id_nxt    = res_id;
        res_sum_nxt   = res_sum;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    g_nxt    = arb_idx;
                    len_nxt  = sel_len;
                    ptr_nxt  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    cnt_nxt  = '0;
                    dcnt_nxt = '0;
                end
            end
            CLEAR: acc_rst_nxt = 1'b1;
            STREAM: begin
                if (hs) begin
                    acc_in_nxt = sel_data;
                    cnt_nxt    = cnt + LENW'(1);
                end
            end
            DRAIN: begin
                dcnt_nxt = dcnt + DCW'(1);
                if (drain_last) begin
                    res_sum_nxt   = acc_sum;
                    res_id_nxt    = g;
                    res_valid_nxt = 1'b1;
                end
            end
            RESULT: if (res_ready) res_valid_nxt = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            g         <= '0;
            len       <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            acc_rst   <= 1'b1;
            acc_in    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            g         <= g_nxt;
            len       <= len_nxt;
            cnt       <= cnt_nxt;
            dcnt      <= dcnt_nxt;
            acc_rst   <= acc_rst_nxt;
            acc_in    <= acc_in_nxt;
            res_valid <= res_valid_nxt;
            res_id    <= res_id_nxt;
            res_sum   <= res_sum_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched with a behavioural one-cycle accumulator.
module tb_acc_sched;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  len;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [15:0] vmask;
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
        bit          chk_lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic [31:0] smp_data;
    logic [3:0]  smp_valid;
    logic [3:0]  smp_ready;
    logic        acc_rst;
    logic [7:0]  acc_in;
    logic [15:0] acc_sum;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_sum;
    logic        res_ready;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  base  [4];
    logic [7:0]  step  [4];
    logic [15:0] vmask [4];
    int          src_cnt [4];
    int          vpos    [4];
    logic [3:0]  src_en;
    logic [3:0]  rdy_prev, hs_prev, ready_seen;
    int          rst_pulses;
    vec_t        vecs [6];

    acc_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .acc_rst   (acc_rst),
        .acc_in    (acc_in),
        .acc_sum   (acc_sum),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External accumulator: one cycle from acc_in to sum, wraps mod 2**16.
    always_ff @(posedge clk) begin
        if (acc_rst) acc_sum <= '0;
        else         acc_sum <= acc_sum + 16'(acc_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            smp_data[i*8 +: 8] = base[i] + 8'(src_cnt[i]) * step[i];
            smp_valid[i] = src_en[i] & ((vpos[i] >= 16) ? 1'b1 : vmask[i][4'(vpos[i])]);
        end
    endtask

    task automatic tick();
        logic [7:0] exp_in;
        exp_in   = 8'h00;
        rdy_prev = smp_ready;
        hs_prev  = smp_valid & smp_ready;
        for (int i = 0; i < 4; i++)
            if (hs_prev[i]) exp_in = smp_data[i*8 +: 8];
        if (!rst) exp_in = 8'h00;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rdy_prev[i]) vpos[i]++;
            if (hs_prev[i])  src_cnt[i]++;
        end
        if (acc_rst) rst_pulses++;
        ready_seen |= smp_ready;
        chk("acc_in", 32'(acc_in), 32'(exp_in));
        chk("ready_onehot0", 32'($onehot0(smp_ready)), 32'd1);
        chk("ready_while_idle", 32'((|smp_ready) && !busy), 32'd0);
        drive();
    endtask

    task automatic set_all(input logic [7:0] l, input logic [7:0] b, input logic [7:0] s,
                           input logic [15:0] m);
        for (int i = 0; i < 4; i++) begin
            req_len[i*8 +: 8] = l;
            base[i]    = b;
            step[i]    = s;
            vmask[i]   = m;
            src_cnt[i] = 0;
            vpos[i]    = 0;
        end
        src_en = 4'hF;
        drive();
    endtask

    task automatic wait_result(input int budget, output int lat);
        lat = 0;
        while (!res_valid && lat < budget) begin
            tick();
            lat++;
        end
        chk("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst = 1'b0; req = '0; req_len = '0; res_ready = 1'b0;
        src_en = '0; smp_data = '0; smp_valid = '0;
        rdy_prev = '0; hs_prev = '0; ready_seen = '0; rst_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            base[i] = '0; step[i] = '0; vmask[i] = 16'hFFFF; src_cnt[i] = 0; vpos[i] = 0;
        end

        //           req      len     base    step   vmask      id    sum        lat
        vecs[0] = '{4'b0001, 8'd3,   8'd10,  8'd10, 16'hFFFF, 2'd0, 16'd60,    1'b1};
        vecs[1] = '{4'b0010, 8'd4,   8'd1,   8'd1,  16'hFFF5, 2'd1, 16'd10,    1'b0};
        vecs[2] = '{4'b0100, 8'd255, 8'hFF,  8'd0,  16'hFFFF, 2'd2, 16'hFE01,  1'b1};
        vecs[3] = '{4'b0100, 8'd0,   8'd7,   8'd1,  16'hFFFF, 2'd2, 16'd0,     1'b1};
        vecs[4] = '{4'b1000, 8'd5,   8'd3,   8'd7,  16'hFFFF, 2'd3, 16'd85,    1'b1};
        vecs[5] = '{4'b0001, 8'd1,   8'd200, 8'd0,  16'hFFFF, 2'd0, 16'd200,   1'b1};

        // Reset values
        tick();
        tick();
        chk("rst_acc_rst",   32'(acc_rst),   32'd1);
        chk("rst_acc_in",    32'(acc_in),    32'd0);
        chk("rst_smp_ready", 32'(smp_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_sum",   32'(res_sum),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b1;
        tick();
        chk("idle_acc_rst", 32'(acc_rst), 32'd0);
        chk("idle_busy",    32'(busy),    32'd0);

        // All four requesting: grants rotate 0,1,2,3,0
        set_all(8'd2, 8'd1, 8'd0, 16'hFFFF);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_result(200, lat);
            chk("rr_id",  32'(res_id),  32'(k % 4));
            chk("rr_sum", 32'(res_sum), 32'd2);
            if (k == 4) req = '0;
            consume();
        end

        // Single-requester frames from the vector table
        for (int v = 0; v < 6; v++) begin
            set_all(vecs[v].len, vecs[v].base, vecs[v].step, vecs[v].vmask);
            rst_pulses = 0;
            ready_seen = '0;
            req = vecs[v].req;
            wait_result(1000, lat);
            chk("vec_id",         32'(res_id),     32'(vecs[v].exp_id));
            chk("vec_sum",        32'(res_sum),    32'(vecs[v].exp_sum));
            chk("vec_acc_rst",    32'(rst_pulses), 32'd1);
            chk("vec_ready_seen", 32'(ready_seen),
                (vecs[v].len == 8'd0) ? 32'd0 : 32'(vecs[v].req));
            if (vecs[v].chk_lat)
                chk("vec_latency", 32'(lat), 32'(vecs[v].len) + 32'd4);
            req = '0;
            consume();
        end

        // Result held while res_ready stays low; no new frame starts
        set_all(8'd2, 8'd1, 8'd0, 16'hFFFF);
        req = 4'hF;
        wait_result(200, lat);
        chk("hold_id",  32'(res_id),  32'd1);
        chk("hold_sum", 32'(res_sum), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid",   32'(res_valid), 32'd1);
            chk("hold_sum_st",  32'(res_sum),   32'd2);
            chk("hold_id_st",   32'(res_id),    32'd1);
            chk("hold_busy",    32'(busy),      32'd1);
            chk("hold_acc_rst", 32'(acc_rst),   32'd0);
        end
        req = '0;
        consume();

        // Reset in the middle of a stream drops the frame and rewinds the pointer
        set_all(8'd10, 8'd1, 8'd1, 16'hFFFF);
        req = 4'b0001;
        n = 0;
        while (!smp_ready[0] && n < 50) begin
            tick();
            n++;
        end
        chk("mid_stream", 32'(smp_ready[0]), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_busy",      32'(busy),      32'd0);
        chk("mrst_smp_ready", 32'(smp_ready), 32'd0);
        chk("mrst_acc_rst",   32'(acc_rst),   32'd1);
        chk("mrst_res_valid", 32'(res_valid), 32'd0);
        rst = 1'b1;
        set_all(8'd1, 8'd5, 8'd0, 16'hFFFF);
        req = 4'hF;
        wait_result(200, lat);
        chk("post_rst_id",  32'(res_id),  32'd0);
        chk("post_rst_sum", 32'(res_sum), 32'd5);
        req = '0;
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
